// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder: field widths, default device ID,
// position of the R/W bit inside the ID byte and the responder state type.
package sccb_pkg;

  localparam int unsigned SCCB_ID_W   = 8;
  localparam int unsigned SCCB_ADDR_W = 8;
  localparam int unsigned SCCB_DATA_W = 8;

  localparam logic [SCCB_ID_W-1:0] SCCB_DEV_ID = 8'h60;

  // Bit 0 of the ID byte selects read (1) or write (0).
  localparam int unsigned SCCB_RW_BIT = 0;

  typedef enum logic [3:0] {
    StIdle,
    StId,
    StIdDc,
    StSub,
    StSubDc,
    StWdata,
    StWdataDc,
    StRdata,
    StRdataNa,
    StSkip
  } sccb_state_e;

endpackage

// File: rtl/sccb_slave_sync.sv
// Input conditioner for the SCCB responder. SIO_C and SIO_D are brought into
// the XCLK domain through SYNC_STAGES flops, then delayed once more so edges
// and bus conditions can be detected on the synchronized values.
//
// Ports:
//   XCLK      system clock, posedge
//   RST_N     synchronous active-low reset
//   scl_in    raw SIO_C
//   sda_in    raw SIO_D (bus value, including our own drive)
//   scl_rise  one-cycle pulse on synchronized SCL rising edge
//   scl_fall  one-cycle pulse on synchronized SCL falling edge
//   start_det SDA fell while SCL high
//   stop_det  SDA rose while SCL high
//   sda_s     synchronized SDA
module sccb_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic XCLK,
  input  logic RST_N,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;
  logic                   scl_s;

  // Reset to the idle bus level (both lines high) so leaving reset on an idle
  // bus produces no spurious events.
  always_ff @(posedge XCLK) begin
    if (!RST_N) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  // SCL must be high on both samples so an SDA change coincident with an SCL
  // edge is never taken as START/STOP.
  assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

endmodule

// File: rtl/sccb_slave.sv
// SCCB 2-wire responder (camera side). Decodes START/STOP, device ID,
// sub-address and data phases; issues register write strobes and serves
// 2-phase reads by pulling SIO_D low (open-drain, never drives 1).
//
// Ports:
//   XCLK     system clock, posedge
//   RST_N    synchronous active-low reset
//   SIO_C    SCCB clock from master
//   SIO_D    SCCB data, driven only to 0 or z
//   wr_en    one-XCLK write strobe
//   wr_addr  register address for wr_en
//   wr_data  register data for wr_en
//   rd_addr  current address pointer to the register store
//   rd_data  register contents at rd_addr (combinational from the store)
//   busy     high from a matched ID until STOP
//   id_match one-XCLK pulse on a matching ID
//
// Build option: define SCCB_SLAVE_ACK_EN to pull SIO_D low during the
// don't-care bit after each byte of a matched transaction; otherwise the
// don't-care bits are left released.
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [SCCB_ID_W-1:0] DEV_ID      = SCCB_DEV_ID,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter int unsigned          ADDR_W      = SCCB_ADDR_W
) (
  input  logic                   XCLK,
  input  logic                   RST_N,
  input  logic                   SIO_C,
  inout  logic                   SIO_D,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [SCCB_DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [SCCB_DATA_W-1:0] rd_data,
  output logic                   busy,
  output logic                   id_match
);

`ifdef SCCB_SLAVE_ACK_EN
  localparam logic AckDrive = 1'b1;
`else
  localparam logic AckDrive = 1'b0;
`endif

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  sccb_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .XCLK     (XCLK),
    .RST_N    (RST_N),
    .scl_in   (SIO_C),
    .sda_in   (SIO_D),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  sccb_state_e            state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [SCCB_DATA_W-1:0] shift_q, shift_d;
  // DC states: the DC bit's rising edge has been seen.
  // RDATA: all 8 bits have been clocked out.
  logic                   mark_q, mark_d;
  logic                   rw_q, rw_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic                   wr_en_q, wr_en_d;
  logic                   id_match_q, id_match_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [SCCB_DATA_W-1:0] wr_data_q, wr_data_d;
  logic [SCCB_DATA_W-1:0] byte_in;

  always_ff @(posedge XCLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      mark_q     <= 1'b0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      id_match_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      mark_q     <= mark_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      id_match_q <= id_match_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign byte_in = {shift_q[SCCB_DATA_W-2:0], sda_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    mark_d     = mark_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_en_d    = 1'b0;
    id_match_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start_det) begin
      state_d = StId;
      cnt_d   = '0;
      mark_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = StIdle;
      cnt_d   = '0;
      mark_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StId, StSub, StWdata: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              mark_d = 1'b0;
              case (state_q)
                StId: begin
                  if (byte_in[SCCB_ID_W-1:1] == DEV_ID[SCCB_ID_W-1:1]) begin
                    id_match_d = 1'b1;
                    busy_d     = 1'b1;
                    rw_d       = byte_in[SCCB_RW_BIT];
                    state_d    = StIdDc;
                  end else begin
                    state_d = StSkip;
                  end
                end
                StSub: begin
                  rd_addr_d = ADDR_W'(byte_in);
                  state_d   = StSubDc;
                end
                default: begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = rd_addr_q;
                  wr_data_d = byte_in;
                  state_d   = StWdataDc;
                end
              endcase
            end
          end
        end
        StIdDc, StSubDc, StWdataDc: begin
          if (scl_rise) begin
            mark_d = 1'b1;
          end
          if (scl_fall) begin
            if (!mark_q) begin
              // Falling edge of the 8th bit: start of the DC bit.
              oe_d = AckDrive;
            end else begin
              mark_d = 1'b0;
              oe_d   = 1'b0;
              if (state_q != StIdDc) begin
                state_d = StWdata;
              end else if (rw_q) begin
                // MSB goes out on this same edge so the master samples it on
                // the next rise.
                state_d = StRdata;
                shift_d = rd_data;
                oe_d    = ~rd_data[SCCB_DATA_W-1];
              end else begin
                state_d = StSub;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              mark_d = 1'b1;
            end
          end
          if (scl_fall) begin
            if (mark_q) begin
              mark_d  = 1'b0;
              oe_d    = 1'b0;
              state_d = StRdataNa;
            end else begin
              shift_d = {shift_q[SCCB_DATA_W-2:0], shift_q[SCCB_DATA_W-1]};
              oe_d    = ~shift_q[SCCB_DATA_W-2];
            end
          end
        end
        StRdataNa: begin
          if (scl_rise) begin
            state_d = StSkip;
          end
        end
        default: ;
      endcase
    end
  end

  assign SIO_D    = oe_q ? 1'b0 : 1'bz;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;
  assign id_match = id_match_q;

endmodule
